// File: rtl/uart_rx_checker.sv
// UART receiver with mid-bit sampling, parity/stop checking, show-ahead receive FIFO,
// sticky error flags and an idle-line timeout.
//
// state    | meaning
// S_IDLE   | line idle, waiting for a synchronized falling edge
// S_START  | half-bit wait, then confirm the start bit is still low
// S_DATA   | sample DATA_BITS bits, LSB first, one per bit period
// S_PARITY | sample and check the parity bit
// S_STOP   | sample STOP_BITS stop bits; a good frame is pushed one cycle later
module uart_rx_checker #(
  parameter int CLKS_PER_BIT   = 868,
  parameter int DATA_BITS      = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun,
  output logic                          idle_timeout
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic                 rx_s1, rx_s2, rx_last;
  logic [2:0]           state;
  logic [TW-1:0]        timer;
  logic [2:0]           bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 frame_bad;
  logic                 push_req;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [IW-1:0]        idle_cnt;

  logic tick, fall, start_entry, parity_bad;
  logic set_frame_err, set_parity_err, set_overrun;
  logic full, do_pop, do_push;

  assign tick        = (timer == '0);
  assign fall        = rx_last & ~rx_s2;
  assign start_entry = (state == S_IDLE) && fall;
  assign parity_bad  = ((^shreg) ^ rx_s2) != (PARITY == 1);

  assign set_frame_err  = (state == S_STOP) && tick && !rx_s2;
  assign set_parity_err = (state == S_PARITY) && tick && parity_bad;

  assign full        = (count == FULL_CNT);
  assign do_pop      = rd_en && (count != '0);
  assign do_push     = push_req && (!full || do_pop);
  assign set_overrun = push_req && full && !do_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_last <= 1'b1;
    end else begin
      rx_s1   <= rx;
      rx_s2   <= rx_s1;
      rx_last <= rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shreg     <= '0;
      frame_bad <= 1'b0;
      push_req  <= 1'b0;
    end else begin
      push_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fall) begin
            state <= S_START;
            timer <= HALF_LOAD;
          end
        end
        S_START: begin
          if (!tick) begin
            timer <= timer - 1'b1;
          end else if (!rx_s2) begin
            state   <= S_DATA;
            timer   <= BIT_LOAD;
            bit_idx <= '0;
          end else begin
            state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (!tick) begin
            timer <= timer - 1'b1;
          end else begin
            shreg <= {rx_s2, shreg[DATA_BITS-1:1]};
            timer <= BIT_LOAD;
            if (bit_idx == LAST_DATA) begin
              state     <= (PARITY != 0) ? S_PARITY : S_STOP;
              stop_idx  <= 1'b0;
              frame_bad <= 1'b0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (!tick) begin
            timer <= timer - 1'b1;
          end else begin
            // A bad parity frame still walks the stop bits so the line stays in step.
            if (parity_bad) frame_bad <= 1'b1;
            state <= S_STOP;
            timer <= BIT_LOAD;
          end
        end
        S_STOP: begin
          if (!tick) begin
            timer <= timer - 1'b1;
          end else begin
            timer <= BIT_LOAD;
            if (!rx_s2) frame_bad <= 1'b1;
            if (stop_idx == LAST_STOP) begin
              state    <= S_IDLE;
              push_req <= !frame_bad && rx_s2;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  // Error events win over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err  <= set_frame_err  | (frame_err  & ~clr_err);
      parity_err <= set_parity_err | (parity_err & ~clr_err);
      overrun    <= set_overrun    | (overrun    & ~clr_err);
    end
  end

  // Restarting on START entry is what drops idle_timeout at the next start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (do_push || start_entry) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_MAX) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign idle_timeout = (idle_cnt == IDLE_MAX);
  assign busy         = (state != S_IDLE);
  assign rd_valid     = (count != '0);
  assign fifo_count   = count;
  assign rd_data      = rd_valid ? 8'(mem[rd_ptr]) : 8'h00;

endmodule

// File: doc/uart_rx_checker.md
UART_RX_CHECKER -- requirements
Module: uart_rx_checker

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits checked; legal values 1 or 2.
REQ-005 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO entries; power of two, 2..256.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1000000, idle cycles before timeout flag.
REQ-007 SHALL have port: clk  input  1  single clock, rising edge.
REQ-008 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-009 SHALL have port: rx  input  1  serial line, idle high; asynchronous to clk.
REQ-010 SHALL have port: rd_en  input  1  pop FIFO head.
REQ-011 SHALL have port: clr_err  input  1  clear sticky error flags.
REQ-012 SHALL have port: rd_data  output  8  FIFO head, show-ahead, zero-extended above DATA_BITS.
REQ-013 SHALL have port: rd_valid  output  1  FIFO not empty.
REQ-014 SHALL have port: fifo_count  output  $clog2(FIFO_DEPTH)+1  entries held.
REQ-015 SHALL have port: busy  output  1  FSM not in IDLE.
REQ-016 SHALL have port: frame_err, parity_err, overrun  output  1 each  sticky error flags.
REQ-017 SHALL have port: idle_timeout  output  1  no valid frame within TIMEOUT_CYCLES.

Function
REQ-018 SHALL pass rx through a 2-flop synchronizer; all sampling uses the synchronized value (2-cycle input latency).
REQ-019 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-020 IDLE: SHALL enter START on a synchronized high-to-low transition.
REQ-021 START: SHALL wait CLKS_PER_BIT/2 cycles, then enter DATA if rx is low, else return to IDLE with no flag (glitch rejection).
REQ-022 DATA: SHALL sample one bit every CLKS_PER_BIT cycles, LSB first, DATA_BITS samples; then enter PARITY if PARITY!=0, else STOP.
REQ-023 PARITY: SHALL sample one bit; on mismatch (odd: data^p must be 1; even: must be 0) SHALL set parity_err and discard the frame.
REQ-024 STOP: SHALL sample STOP_BITS bits at CLKS_PER_BIT spacing; any low sample SHALL set frame_err and discard the frame.
REQ-025 SHALL push a good frame into the FIFO in the cycle after the last stop sample, then return to IDLE.
REQ-026 Push while full and no pop SHALL drop the byte, set overrun, and leave FIFO contents unchanged.
REQ-027 Simultaneous push and pop SHALL both take effect, including when full (count unchanged).
REQ-028 rd_en while empty SHALL be ignored with no state change.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 clr_err SHALL clear all three error flags next cycle; an error event in the same cycle SHALL take precedence and keep its flag set.
REQ-031 Idle counter SHALL increment each cycle, saturate at TIMEOUT_CYCLES, and reset to 0 on each FIFO push.
REQ-032 idle_timeout SHALL be high while the counter equals TIMEOUT_CYCLES and SHALL clear on the next START entry.

Reset
REQ-033 rst SHALL force IDLE, set synchronizer flops to 1, and clear FIFO pointers, count, bit counters and idle counter.
REQ-034 During and after reset: rd_valid=0, fifo_count=0, rd_data=0, busy=0, all error flags=0, idle_timeout=0.
REQ-035 rst mid-frame SHALL abort the frame without flag or push; reception restarts at the next start edge.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4, TIMEOUT_CYCLES=200 unless stated)
REQ-036 Send 8N1 frames 0x55 then 0xA3 -> rd_valid=1, fifo_count=2, rd_data=0x55; after one rd_en, rd_data=0xA3.
REQ-037 PARITY=2, send 0x07 with parity bit 0 -> parity_err=1, fifo_count=0; clr_err pulse -> parity_err=0.
REQ-038 Send 0x3C with stop bit driven low -> frame_err=1, no push; the following good frame 0x11 is received correctly.
REQ-039 Send 5 frames without reads -> fifo_count=4, overrun=1, FIFO holds frames 1-4; push coincident with rd_en at full -> count stays 4, overrun unchanged.
REQ-040 Line low for 1 cycle only -> busy returns to 0, no flags; hold rx high 200 cycles after reset -> idle_timeout=1; next start edge -> idle_timeout=0.
REQ-041 Assert rst during DATA bit 3 -> all outputs at reset values next cycle; subsequent frame 0xF0 received intact.
